rdma_rc_pdu_classify: RTL and testbench
=======================================

Name: rdma_rc_pdu_classify

Overview:
Receive-side BTH parser that sits directly upstream of the RC credit/flow block. It consumes a 32-bit word stream with sop/eop framing and extracts the opcode from the 3-word BTH. It filters packets by destination QP, QP state and PSN. Each accepted packet produces exactly one is_data_frame or is_control_frame pulse, with pdu_opcode, for the credit block.

Parameters:
QPN_WIDTH, 24, destination QP / PSN field width
DROP_CNT_WIDTH, 16, saturating drop counter width
PKEY_DEFAULT, 16'hFFFF, expected partition key (used only with the optional feature)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
qp_num_cfg  in  24  local QP number to accept
psn_init_cfg  in  24  starting expected PSN
qp_state  in  3  QP state; RTS=3'b011
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  32  input word
s_sop  in  1  first word of packet
s_eop  in  1  last word of packet
pdu_opcode  out  8  opcode of emitted frame; held until the next emit
is_data_frame  out  1  one-cycle pulse: data PDU accepted
is_control_frame  out  1  one-cycle pulse: control PDU accepted
expected_psn  out  24  next expected data PSN
psn_err  out  1  one-cycle pulse: data PSN mismatch
drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Reset values: s_ready=0, pdu_opcode=0, both frame pulses=0, expected_psn=0, psn_err=0, drop_cnt=0, FSM=IDLE.
- s_ready=1 in every cycle after reset release. A word transfers only when s_valid&s_ready. All FSM transitions occur on transfer cycles only.
- BTH layout:
  - word0: opcode[31:24], pkey[15:0]
  - word1: destQP[23:0]
  - word2: PSN[23:0]
- Opcode classes:
  - data: opcode[7:5]==3'b000 (0x00-0x1F)
  - control: 0x20 ACK, 0x21 NAK, 0x22 CNP
  - anything else is unknown.
- FSM states and transitions:
  - IDLE: a word with sop latches the opcode and goes to HDR1. A word without sop is ignored and not counted.
  - HDR1: if destQP!=qp_num_cfg -> DROP, else -> HDR2.
  - HDR2: if the opcode is unknown, or qp_state!=RTS -> DROP. If the opcode is data and PSN!=expected_psn -> DROP and pulse psn_err. Otherwise -> BODY.
  - BODY: waits for eop.
  - DROP: consumes words until eop.
- eop in BODY, or eop on word2 in HDR2 when the packet passes: the next cycle pulses is_data_frame or is_control_frame and updates pdu_opcode. Latency is 1 clk from eop transfer to pulse. The FSM returns to IDLE.
- On a data emit, expected_psn increments modulo 2^24 (0xFFFFFF -> 0x000000). Control frames neither check nor advance the PSN.
- Runt packets (eop in HDR0 via a sop&eop word, or eop in HDR1) are dropped with no pulse.
- sop while not in IDLE: the current packet is aborted and counted as a drop, and the new word is parsed as word0 (-> HDR1).
- drop_cnt increments by 1 per dropped packet, counted at the eop or abort transfer, and saturates at all-ones.
- expected_psn loads psn_init_cfg on the cycle qp_state transitions into RTS from any other state. A load coinciding with a data emit takes the load.
- When qp_state leaves RTS mid-packet, the state is sampled at word2 only. An already-passed packet still emits.
- A reset mid-packet returns all state to the reset values immediately, with no pulse.

Optional Feature:
RDMA_RC_PKEY_CHECK_EN
- Defined: word0 pkey!=PKEY_DEFAULT forces DROP at HDR1, counted in drop_cnt.
- Undefined: pkey is ignored and no comparator is built.

Decomposition:
- rdma_rc_pkg holds:
  - the QP state encodings (RESET, INIT, RTR, RTS=3'b011, ...)
  - the opcode constants OPC_ACK=8'h20, OPC_NAK=8'h21, OPC_CNP=8'h22
  - the data-class mask
  - the FSM state enum (IDLE, HDR1, HDR2, BODY, DROP)
  - the BTH field bit-positions.
- One sub-module: rdma_rc_sat_cnt, a parameterised saturating counter used for drop_cnt.

Test Plan:
- Reset then qp_state=RTS, psn_init_cfg=0x000100 -> expected_psn=0x000100, drop_cnt=0, s_ready=1 one cycle after rst_n rises.
- 4-word data packet: opcode 0x04, destQP=qp_num_cfg, PSN 0x000100 -> is_data_frame pulse 1 clk after eop, pdu_opcode=0x04, expected_psn=0x000101.
- ACK packet: opcode 0x20 with arbitrary PSN 0x123456 -> is_control_frame pulse, pdu_opcode=0x20, expected_psn unchanged.
- Data packet with PSN 0x000105 while expected is 0x000101 -> psn_err pulse, no frame pulse, drop_cnt+1.
- Wrong destQP; opcode 0x40; 2-word runt; sop mid-packet -> each gives drop_cnt+1 with no pulse. The aborted-then-restarted packet still emits if valid.
- psn_init_cfg=0xFFFFFF, two valid data packets -> expected_psn wraps to 0x000000 then 0x000001.

Source files
------------

// File: rtl/rdma_rc_pkg.sv
// Shared encodings for the RC receive path: QP states, BTH opcodes/fields and
// the classifier FSM states.
package rdma_rc_pkg;

   typedef enum logic [2:0] {
      QPS_RESET = 3'b000,
      QPS_INIT  = 3'b001,
      QPS_RTR   = 3'b010,
      QPS_RTS   = 3'b011,
      QPS_SQD   = 3'b100,
      QPS_SQE   = 3'b101,
      QPS_ERR   = 3'b110
   } qp_state_e;

   localparam logic [7:0] OPC_ACK = 8'h20;
   localparam logic [7:0] OPC_NAK = 8'h21;
   localparam logic [7:0] OPC_CNP = 8'h22;

   // Data opcodes occupy 0x00-0x1F: top three bits clear.
   localparam logic [7:0] OPC_DATA_MASK = 8'hE0;
   localparam logic [7:0] OPC_DATA_VAL  = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR1,
      ST_HDR2,
      ST_BODY,
      ST_DROP
   } fsm_e;

   localparam int unsigned BTH_OPC_LSB  = 24;
   localparam int unsigned BTH_PKEY_LSB = 0;
   localparam int unsigned BTH_QPN_LSB  = 0;
   localparam int unsigned BTH_PSN_LSB  = 0;

   function automatic logic opc_is_data(input logic [7:0] opc);
      return (opc & OPC_DATA_MASK) == OPC_DATA_VAL;
   endfunction

   function automatic logic opc_is_ctrl(input logic [7:0] opc);
      return (opc == OPC_ACK) || (opc == OPC_NAK) || (opc == OPC_CNP);
   endfunction

endpackage

// File: rtl/rdma_rc_sat_cnt.sv
// Saturating up-counter; adds a small increment per cycle and sticks at all-ones.
module rdma_rc_sat_cnt #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned INC_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [INC_W-1:0] inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   sum;

   always_comb begin
      sum   = {1'b0, cnt_q} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
      cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/rdma_rc_pdu_classify.sv
// RC receive BTH classifier: filters by dest QP, QP state and PSN, and emits one
// data/control pulse per accepted packet. Optional pkey filter: RDMA_RC_PKEY_CHECK_EN.
import rdma_rc_pkg::*;

module rdma_rc_pdu_classify #(
   parameter int unsigned QPN_WIDTH      = 24,
   parameter int unsigned DROP_CNT_WIDTH = 16,
   parameter logic [15:0] PKEY_DEFAULT   = 16'hFFFF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [QPN_WIDTH-1:0]      qp_num_cfg,
   input  logic [QPN_WIDTH-1:0]      psn_init_cfg,
   input  logic [2:0]                qp_state,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [31:0]               s_data,
   input  logic                      s_sop,
   input  logic                      s_eop,
   output logic [7:0]                pdu_opcode,
   output logic                      is_data_frame,
   output logic                      is_control_frame,
   output logic [QPN_WIDTH-1:0]      expected_psn,
   output logic                      psn_err,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   fsm_e                 state_q, state_d;
   logic [7:0]           opc_q, opc_d;
   logic [7:0]           pdu_opcode_q, pdu_opcode_d;
   logic                 is_data_q, is_data_d;
   logic                 is_ctrl_q, is_ctrl_d;
   logic                 psn_err_q, psn_err_d;
   logic [QPN_WIDTH-1:0] exp_psn_q, exp_psn_d;
   logic                 rts_prev_q, rts_prev_d;
   logic                 s_ready_q, s_ready_d;

   logic       xfer, emit, hdr_bad, psn_bad, pkey_bad, rts_now;
   logic [1:0] drop_add;

`ifdef RDMA_RC_PKEY_CHECK_EN
   logic [15:0] pkey_q, pkey_d;

   always_comb begin
      pkey_d = pkey_q;
      if (xfer && s_sop) pkey_d = s_data[BTH_PKEY_LSB +: 16];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pkey_q <= '0;
      else        pkey_q <= pkey_d;
   end

   assign pkey_bad = (pkey_q != PKEY_DEFAULT);
`else
   logic unused_pkey;
   assign unused_pkey = ^PKEY_DEFAULT;
   assign pkey_bad    = 1'b0;
`endif

   assign rts_now = (qp_state == QPS_RTS);

   always_comb begin
      xfer      = s_valid & s_ready_q;
      state_d   = state_q;
      opc_d     = opc_q;
      emit      = 1'b0;
      hdr_bad   = 1'b0;
      psn_bad   = 1'b0;
      drop_add  = 2'd0;
      psn_err_d = 1'b0;
      s_ready_d = 1'b1;

      if (xfer) begin
         if (s_sop) begin
            // A sop anywhere restarts parsing; an open packet is abandoned as a drop.
            if (state_q != ST_IDLE) drop_add = drop_add + 2'd1;
            opc_d = s_data[BTH_OPC_LSB +: 8];
            if (s_eop) begin
               drop_add = drop_add + 2'd1;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_HDR1;
            end
         end else begin
            case (state_q)
               ST_IDLE: state_d = ST_IDLE;
               ST_HDR1: begin
                  if (s_eop) begin
                     drop_add = 2'd1;
                     state_d  = ST_IDLE;
                  end else if (s_data[BTH_QPN_LSB +: QPN_WIDTH] != qp_num_cfg || pkey_bad) begin
                     state_d  = ST_DROP;
                  end else begin
                     state_d  = ST_HDR2;
                  end
               end
               ST_HDR2: begin
                  hdr_bad   = !(opc_is_data(opc_q) || opc_is_ctrl(opc_q)) || !rts_now;
                  psn_bad   = !hdr_bad && opc_is_data(opc_q) &&
                              (s_data[BTH_PSN_LSB +: QPN_WIDTH] != exp_psn_q);
                  psn_err_d = psn_bad;
                  if (hdr_bad || psn_bad) begin
                     if (s_eop) begin
                        drop_add = 2'd1;
                        state_d  = ST_IDLE;
                     end else begin
                        state_d  = ST_DROP;
                     end
                  end else if (s_eop) begin
                     emit    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_BODY;
                  end
               end
               ST_BODY: begin
                  if (s_eop) begin
                     emit    = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               ST_DROP: begin
                  if (s_eop) begin
                     drop_add = 2'd1;
                     state_d  = ST_IDLE;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end

      is_data_d    = emit & opc_is_data(opc_q);
      is_ctrl_d    = emit & opc_is_ctrl(opc_q);
      pdu_opcode_d = emit ? opc_q : pdu_opcode_q;

      // Entering RTS reloads the PSN and wins over a coincident data emit.
      rts_prev_d = rts_now;
      exp_psn_d  = exp_psn_q;
      if (rts_now && !rts_prev_q) exp_psn_d = psn_init_cfg;
      else if (is_data_d)         exp_psn_d = exp_psn_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         opc_q        <= '0;
         pdu_opcode_q <= '0;
         is_data_q    <= 1'b0;
         is_ctrl_q    <= 1'b0;
         psn_err_q    <= 1'b0;
         exp_psn_q    <= '0;
         rts_prev_q   <= 1'b0;
         s_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         pdu_opcode_q <= pdu_opcode_d;
         is_data_q    <= is_data_d;
         is_ctrl_q    <= is_ctrl_d;
         psn_err_q    <= psn_err_d;
         exp_psn_q    <= exp_psn_d;
         rts_prev_q   <= rts_prev_d;
         s_ready_q    <= s_ready_d;
      end
   end

   rdma_rc_sat_cnt #(
      .WIDTH (DROP_CNT_WIDTH),
      .INC_W (2)
   ) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop_add),
      .cnt   (drop_cnt)
   );

   assign s_ready          = s_ready_q;
   assign pdu_opcode       = pdu_opcode_q;
   assign is_data_frame    = is_data_q;
   assign is_control_frame = is_ctrl_q;
   assign psn_err          = psn_err_q;
   assign expected_psn     = exp_psn_q;

endmodule

// File: tb/tb_rdma_rc_pdu_classify.sv
// Directed bench for rdma_rc_pdu_classify: stimulus pushes expected pulses into
// a queue that a negedge monitor pops and compares.
module tb_rdma_rc_pdu_classify;

   localparam logic [23:0] QPN = 24'h00ABCD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] qp_num_cfg, psn_init_cfg;
   logic [2:0]  qp_state;
   logic        s_valid, s_ready, s_sop, s_eop;
   logic [31:0] s_data;
   logic [7:0]  pdu_opcode;
   logic        is_data_frame, is_control_frame, psn_err;
   logic [23:0] expected_psn;
   logic [15:0] drop_cnt;

   typedef struct {
      int          kind;   // 1 data, 2 control, 3 psn_err
      logic [7:0]  opc;
      logic [23:0] psn;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   ntests = 0;
   int   nfail  = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rdma_rc_pdu_classify dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .qp_num_cfg       (qp_num_cfg),
      .psn_init_cfg     (psn_init_cfg),
      .qp_state         (qp_state),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .s_sop            (s_sop),
      .s_eop            (s_eop),
      .pdu_opcode       (pdu_opcode),
      .is_data_frame    (is_data_frame),
      .is_control_frame (is_control_frame),
      .expected_psn     (expected_psn),
      .psn_err          (psn_err),
      .drop_cnt         (drop_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] opc, input logic [23:0] psn);
      exp_t e;
      e.kind = kind;
      e.opc  = opc;
      e.psn  = psn;
      e.cyc  = cyc;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic sop, input logic eop);
      s_data  = w;
      s_sop   = sop;
      s_eop   = eop;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
   endtask

   // kind: 0 = no pulse expected, 1 data, 2 control, 3 psn_err at word2
   task automatic send_pkt(input logic [7:0] opc, input logic [23:0] qpn, input logic [23:0] psn,
                           input int nw, input int kind, input logic [23:0] epsn, input bit gap);
      logic [31:0] w;
      for (int i = 0; i < nw; i++) begin
         case (i)
            0:       w = {opc, 8'h00, 16'hFFFF};
            1:       w = {8'h00, qpn};
            2:       w = {8'h00, psn};
            default: w = 32'hC0DE_0000 + i;
         endcase
         send_word(w, i == 0, i == nw - 1);
         if (kind == 3 && i == 2) push(3, opc, epsn);
         if ((kind == 1 || kind == 2) && i == nw - 1) push(kind, opc, epsn);
         if (gap && i == 1) idle(1);
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   initial begin
      int   kind;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (is_data_frame || is_control_frame || psn_err)) begin
            kind = psn_err ? 3 : (is_data_frame ? 1 : 2);
            if (sb.size() == 0) begin
               ntests++;
               nfail++;
               $display("FAIL unexpected_pulse: got kind %0d opcode 0x%0h, expected no pulse",
                        kind, pdu_opcode);
            end else begin
               e = sb.pop_front();
               chk("pulse_kind", kind, e.kind);
               chk("pulse_cycle", cyc, e.cyc);
               if (kind != 3) begin
                  chk("pdu_opcode", {24'h0, pdu_opcode}, {24'h0, e.opc});
                  chk("expected_psn_at_emit", {8'h0, expected_psn}, {8'h0, e.psn});
               end
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      qp_state     = 3'b000;
      qp_num_cfg   = QPN;
      psn_init_cfg = 24'h000100;
      s_valid      = 1'b0;
      s_sop        = 1'b0;
      s_eop        = 1'b0;
      s_data       = '0;
      idle(3);
      chk("rst_s_ready", {31'h0, s_ready}, 0);
      chk("rst_expected_psn", {8'h0, expected_psn}, 0);
      chk("rst_drop_cnt", {16'h0, drop_cnt}, 0);
      chk("rst_pdu_opcode", {24'h0, pdu_opcode}, 0);
      chk("rst_pulses", {29'h0, is_data_frame, is_control_frame, psn_err}, 0);

      rst_n    = 1'b1;
      qp_state = 3'b011;
      idle(1);
      chk("s_ready_after_rst", {31'h0, s_ready}, 1);
      chk("psn_init_load", {8'h0, expected_psn}, 32'h100);
      chk("drop_cnt_init", {16'h0, drop_cnt}, 0);

      // Data packet with a valid gap mid-packet
      send_pkt(8'h04, QPN, 24'h000100, 4, 1, 24'h000101, 1'b1);
      idle(2);
      // ACK (eop on word2) and CNP: no PSN check or advance
      send_pkt(8'h20, QPN, 24'h123456, 3, 2, 24'h000101, 1'b0);
      send_pkt(8'h22, QPN, 24'h000000, 4, 2, 24'h000101, 1'b0);
      idle(1);
      chk("psn_after_ctrl", {8'h0, expected_psn}, 32'h101);

      // PSN mismatch
      send_pkt(8'h0A, QPN, 24'h000105, 4, 3, 24'h0, 1'b0);
      chk("drop_psn_err", {16'h0, drop_cnt}, 1);
      chk("opcode_held", {24'h0, pdu_opcode}, 32'h22);

      // Wrong destQP, unknown opcode, 2-word runt
      send_pkt(8'h04, QPN ^ 24'h1, 24'h000101, 4, 0, 24'h0, 1'b0);
      chk("drop_bad_qp", {16'h0, drop_cnt}, 2);
      send_pkt(8'h40, QPN, 24'h000101, 4, 0, 24'h0, 1'b0);
      chk("drop_unknown_opc", {16'h0, drop_cnt}, 3);
      send_pkt(8'h04, QPN, 24'h000101, 2, 0, 24'h0, 1'b0);
      chk("drop_runt2", {16'h0, drop_cnt}, 4);

      // Abort by sop mid-packet, restarted packet still emits
      send_word({8'h04, 8'h00, 16'hFFFF}, 1'b1, 1'b0);
      send_word({8'h00, QPN}, 1'b0, 1'b0);
      send_pkt(8'h06, QPN, 24'h000101, 4, 1, 24'h000102, 1'b0);
      chk("drop_abort", {16'h0, drop_cnt}, 5);

      // Single-word sop&eop runt, then a stray non-sop word in IDLE
      send_word({8'h04, 8'h00, 16'hFFFF}, 1'b1, 1'b1);
      chk("drop_runt1", {16'h0, drop_cnt}, 6);
      send_word(32'h0000_1234, 1'b0, 1'b1);
      chk("idle_stray_ignored", {16'h0, drop_cnt}, 6);
      send_pkt(8'h21, QPN, 24'h000000, 3, 2, 24'h000102, 1'b0);

      // Not RTS at word2
      qp_state = 3'b010;
      idle(1);
      send_pkt(8'h20, QPN, 24'h000000, 3, 0, 24'h0, 1'b0);
      chk("drop_not_rts", {16'h0, drop_cnt}, 7);
      chk("psn_hold_not_rts", {8'h0, expected_psn}, 32'h102);

      // Re-enter RTS with a new initial PSN, then wrap
      psn_init_cfg = 24'hFFFFFF;
      qp_state     = 3'b011;
      idle(1);
      chk("psn_reload", {8'h0, expected_psn}, 32'hFFFFFF);
      send_pkt(8'h00, QPN, 24'hFFFFFF, 3, 1, 24'h000000, 1'b0);
      send_pkt(8'h1F, QPN, 24'h000000, 4, 1, 24'h000001, 1'b0);
      idle(1);
      chk("psn_after_wrap", {8'h0, expected_psn}, 32'h1);

      // Reset mid-packet
      send_word({8'h04, 8'h00, 16'hFFFF}, 1'b1, 1'b0);
      send_word({8'h00, QPN}, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_expected_psn", {8'h0, expected_psn}, 0);
      chk("midrst_drop_cnt", {16'h0, drop_cnt}, 0);
      chk("midrst_s_ready", {31'h0, s_ready}, 0);
      chk("midrst_pdu_opcode", {24'h0, pdu_opcode}, 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
